// File: rtl/bit_rev_pkg.sv
// Shared definitions for the bit-reverse scatter and collect stages.
//
// Contents:
//   LANES   - words per beat (32)
//   DEPTH   - beats per frame (16)
//   LANE_W  - lane index width (bit4 = half, bits3:0 = rotated slot)
//   BEAT_W  - beat counter width
//   bitrev4   - reverse the four bits of a slot index
//   derot_col - bank column that input lane s of beat c lands in
package bit_rev_pkg;

    localparam int LANES  = 32;
    localparam int DEPTH  = 16;
    localparam int LANE_W = 5;
    localparam int BEAT_W = 4;

    function automatic logic [3:0] bitrev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    // The slot subtraction is 4 bits wide and wraps; the half bit passes through.
    function automatic logic [LANE_W-1:0] derot_col(input logic [LANE_W-1:0] s,
                                                    input logic [BEAT_W-1:0] c);
        logic [BEAT_W-1:0] w_slot;
        w_slot = bitrev4(s[3:0]) - c;
        return {s[4], w_slot};
    endfunction

endpackage

// File: rtl/bit_rev_bank.sv
// One frame bank: 16 rows x 32 words of register storage.
//
// Ports:
//   clk    - rising-edge clock
//   i_we   - write the beat on i_data into row i_row
//   i_row  - beat index of the incoming beat
//   i_data - 32 lanes of the incoming beat (lane s at [DATA_W*s +: DATA_W])
//   i_col  - output beat index j
//   o_data - gathered beat; lane l comes from row l[3:0], column {l[4], j}
//
// Storage is deliberately not reset; the full flags in the top level decide
// whether its contents mean anything.
module bit_rev_bank
    import bit_rev_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [BEAT_W-1:0]       i_row,
    input  logic [DATA_W*LANES-1:0] i_data,
    input  logic [BEAT_W-1:0]       i_col,
    output logic [DATA_W*LANES-1:0] o_data
);

    logic [DATA_W-1:0] r_mem [DEPTH][LANES];

    // De-rotating write: each lane is undone from its rotated, bit-reversed slot.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int s = 0; s < LANES; s++) begin
                r_mem[i_row][derot_col(LANE_W'(s), i_row)] <= i_data[DATA_W*s +: DATA_W];
            end
        end
    end

    // Column gather: reading down a column transposes the frame.
    always_comb begin
        o_data = '0;
        for (int l = 0; l < LANES; l++) begin
            o_data[DATA_W*l +: DATA_W] = r_mem[BEAT_W'(l)][{1'(l >> 4), i_col}];
        end
    end

endmodule

// File: rtl/bit_reverse_collect.sv
// Receive-side collector: undoes per-beat rotation and bit reversal, then
// transposes each 16-beat frame so it leaves in natural coefficient order.
// Two banks ping-pong so frames can stream back to back.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous, active-low reset
//   in_valid  / in_ready / in_last / in_data    - input beat handshake
//   out_valid / out_ready / out_last / out_data - output beat handshake
//   frame_err - sticky flag: in_last disagreed with the internal beat counter
module bit_reverse_collect
    import bit_rev_pkg::*;
#(
    parameter int DATA_SIZE_ARB = 32,
    parameter int PE_NUMBER     = 32,
    parameter int DEPTH         = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    input  logic [DATA_SIZE_ARB*PE_NUMBER-1:0] in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic [DATA_SIZE_ARB*PE_NUMBER-1:0] out_data,
    output logic                              frame_err
);

    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [BEAT_W-1:0] r_wr_cnt;
    logic [BEAT_W-1:0] r_rd_cnt;
    logic [1:0]        r_bank_full;
    logic              r_frame_err;

    logic w_accept;
    logic w_rd_fire;
    logic w_wr_last;
    logic w_rd_last;
    logic [1:0] w_full_next;
    logic [DATA_SIZE_ARB*PE_NUMBER-1:0] w_rd_data [2];

    assign in_ready  = !r_bank_full[r_wr_bank];
    assign out_valid = r_bank_full[r_rd_bank];
    assign w_accept  = in_valid && in_ready;
    assign w_rd_fire = out_valid && out_ready;
    assign w_wr_last = (r_wr_cnt == BEAT_W'(DEPTH - 1));
    assign w_rd_last = (r_rd_cnt == BEAT_W'(DEPTH - 1));
    assign out_last  = out_valid && w_rd_last;
    assign out_data  = w_rd_data[r_rd_bank];
    assign frame_err = r_frame_err;

    // The set targets the write bank and the clear targets the read bank; when
    // both happen in one cycle those are always different banks.
    always_comb begin
        w_full_next = r_bank_full;
        if (w_accept && w_wr_last) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_rd_fire && w_rd_last) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    // Counters, bank pointers and full flags. The beat counter is the framing
    // authority; a disagreeing in_last only raises the sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_bank_full <= 2'b00;
            r_frame_err <= 1'b0;
        end else begin
            r_bank_full <= w_full_next;
            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + BEAT_W'(1);
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
                if (in_last != w_wr_last) begin
                    r_frame_err <= 1'b1;
                end
            end
            if (w_rd_fire) begin
                r_rd_cnt <= r_rd_cnt + BEAT_W'(1);
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bit_rev_bank #(
            .DATA_W(DATA_SIZE_ARB)
        ) u_bank (
            .clk   (clk),
            .i_we  (w_accept && (r_wr_bank == 1'(b))),
            .i_row (r_wr_cnt),
            .i_data(in_data),
            .i_col (r_rd_cnt),
            .o_data(w_rd_data[b])
        );
    end

endmodule

// File: tb/tb_bit_reverse_collect.sv
module tb_bit_reverse_collect;

   localparam int DW = 32;
   localparam int NL = 32;
   localparam int BW = DW * NL;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic          in_last;
   logic [BW-1:0] in_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic [BW-1:0] out_data;
   logic          frame_err;

   int testsRun = 0;
   int testsFailed = 0;
   int readyMode = 0;
   int beatIdx = 0;
   int stallCount = 0;
   int fireCount = 0;

   // Reference model: complete frames in input order (beat*32 + lane), 512 words each.
   logic [31:0] wq[$];
   logic [31:0] part [512];
   int wcnt = 0;
   int rcnt = 0;
   logic errModel = 1'b0;
   int mPend;
   int mBad;
   int mC;
   int mS;
   logic [31:0] mExpLane;
   logic [31:0] mActLane;

   bit_reverse_collect dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_last  (in_last),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last),
      .out_data (out_data),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   function automatic int rev4(input int x);
      return ((x & 1) << 3) | ((x & 2) << 1) | ((x & 4) >> 1) | ((x & 8) >> 3);
   endfunction

   function automatic logic [31:0] laneOf(input logic [BW-1:0] v, input int l);
      return v[DW*l +: DW];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Output beat j, lane l of a frame is input beat l[3:0], lane {l[4], rev(j + l[3:0])}.
   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         wq.delete();
         wcnt = 0;
         rcnt = 0;
         errModel = 1'b0;
      end else begin
         mPend = wq.size() / 512;
         checkOutput("in_ready", 64'(in_ready), 64'(mPend < 2));
         checkOutput("out_valid", 64'(out_valid), 64'(mPend > 0));
         checkOutput("frame_err", 64'(frame_err), 64'(errModel));
         if (mPend > 0) begin
            checkOutput("out_last", 64'(out_last), 64'(rcnt == 15));
            mBad = 0;
            for (int l = NL - 1; l >= 0; l--) begin
               mC = l % 16;
               mS = (l / 16) * 16 + rev4((rcnt + mC) % 16);
               if (laneOf(out_data, l) !== wq[mC * 32 + mS]) mBad = l;
            end
            mC = mBad % 16;
            mS = (mBad / 16) * 16 + rev4((rcnt + mC) % 16);
            mExpLane = wq[mC * 32 + mS];
            mActLane = laneOf(out_data, mBad);
            checkOutput($sformatf("out_data beat%0d lane%0d", rcnt, mBad), 64'(mActLane), 64'(mExpLane));
            if (out_ready) begin
               fireCount++;
               rcnt++;
               if (rcnt == 16) begin
                  rcnt = 0;
                  repeat (512) void'(wq.pop_front());
               end
            end
         end else begin
            checkOutput("out_last_idle", 64'(out_last), 64'd0);
         end
         if (in_valid && mPend < 2) begin
            for (int s = 0; s < NL; s++) part[wcnt * 32 + s] = laneOf(in_data, s);
            if (in_last != (wcnt == 15)) errModel = 1'b1;
            if (wcnt == 15) begin
               for (int k = 0; k < 512; k++) wq.push_back(part[k]);
            end
            wcnt = (wcnt + 1) % 16;
         end
      end
   end

   // Downstream ready generator: 0 = hold low, 1 = hold high, other = random.
   always begin
      @(posedge clk);
      #1;
      case (readyMode)
         0: out_ready = 1'b0;
         1: out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(1, 0));
      endcase
   end

   task automatic applyStimulus(input logic [BW-1:0] data, input int idleMax, input logic extraLast);
      int guard;
      int idle;
      logic acc;
      idle = (idleMax > 0) ? int'($urandom_range(idleMax, 0)) : 0;
      repeat (idle) begin
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data = data;
      in_last = (beatIdx == 15) || extraLast;
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (!acc) stallCount++;
         guard++;
      end
      if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      in_last = 1'b0;
      beatIdx = (beatIdx + 1) % 16;
   endtask

   function automatic logic [BW-1:0] randBeat();
      logic [BW-1:0] v;
      for (int s = 0; s < NL; s++) v[DW*s +: DW] = $urandom;
      return v;
   endfunction

   task automatic waitDrain(input int limit);
      int n;
      n = 0;
      while (wq.size() != 0 && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain", 64'(wq.size() / 512), 64'd0);
   endtask

   initial begin
      logic [BW-1:0] d;
      int f0;
      reset = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = '0;
      #1 reset = 1'b0;
      #2;
      checkOutput("reset in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset out_last", 64'(out_last), 64'd0);
      checkOutput("reset frame_err", 64'(frame_err), 64'd0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;

      // Identity frame: lane s of beat c carries {c, s}; outputs stepped one beat at a time.
      readyMode = 0;
      for (int c = 0; c < 16; c++) begin
         for (int s = 0; s < NL; s++) d[DW*s +: DW] = {16'h0, 8'(c), 8'(s)};
         applyStimulus(d, 0, 1'b0);
         if (c == 14) checkOutput("valid_before_last", 64'(out_valid), 64'd0);
      end
      checkOutput("valid_latency", 64'(out_valid), 64'd1);
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         if (j == 0) checkOutput("id b0 l0", 64'(laneOf(out_data, 0)), 64'h0000);
         if (j == 1) checkOutput("id b1 l0", 64'(laneOf(out_data, 0)), 64'h0008);
         if (j == 1) checkOutput("id b1 l2", 64'(laneOf(out_data, 2)), 64'h020C);
         if (j == 3) checkOutput("id b3 l17", 64'(laneOf(out_data, 17)), 64'h0112);
         if (j == 14) checkOutput("id last b14", 64'(out_last), 64'd0);
         if (j == 15) checkOutput("id last b15", 64'(out_last), 64'd1);
         readyMode = 1;
         @(posedge clk);
         #2 readyMode = 0;
         @(posedge clk);
      end
      @(negedge clk);
      checkOutput("id drained", 64'(out_valid), 64'd0);

      // Three frames back to back with the sink always ready.
      readyMode = 1;
      @(posedge clk);
      #2;
      stallCount = 0;
      f0 = fireCount;
      for (int b = 0; b < 48; b++) applyStimulus(randBeat(), 0, 1'b0);
      repeat (16) @(posedge clk);
      #1;
      checkOutput("b2b input stalls", 64'(stallCount), 64'd0);
      checkOutput("b2b output beats", 64'(fireCount - f0), 64'd48);

      // Backpressure: two frames fill both banks, then drain.
      readyMode = 0;
      @(posedge clk);
      #2;
      stallCount = 0;
      for (int b = 0; b < 32; b++) applyStimulus(randBeat(), 0, 1'b0);
      checkOutput("bp accepts unstalled", 64'(stallCount), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp in_ready low", 64'(in_ready), 64'd0);
      readyMode = 1;
      waitDrain(100);
      checkOutput("bp in_ready back", 64'(in_ready), 64'd1);

      // Async reset with one full frame and nine beats buffered.
      readyMode = 0;
      for (int b = 0; b < 25; b++) applyStimulus(randBeat(), 0, 1'b0);
      #2 reset = 1'b0;
      #1;
      checkOutput("rst out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      beatIdx = 0;
      readyMode = 1;
      for (int b = 0; b < 16; b++) applyStimulus(randBeat(), 0, 1'b0);
      waitDrain(100);

      // Random valid/ready toggling over 20 frames.
      readyMode = 2;
      for (int b = 0; b < 320; b++) applyStimulus(randBeat(), 2, 1'b0);
      readyMode = 1;
      waitDrain(200);
      checkOutput("random frame_err", 64'(frame_err), 64'd0);

      // Framing error: spurious in_last on beat 7.
      for (int b = 0; b < 16; b++) begin
         applyStimulus(randBeat(), 0, b == 7);
         if (b == 6) checkOutput("ferr before", 64'(frame_err), 64'd0);
         if (b == 7) checkOutput("ferr set", 64'(frame_err), 64'd1);
      end
      waitDrain(100);
      checkOutput("ferr sticky", 64'(frame_err), 64'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #500000;
      testsFailed++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
